// File: rtl/dds_sweep_pkg.sv
// Shared types and default widths for the DDS frequency-sweep controller.
package dds_sweep_pkg;

    localparam int PINC_WIDTH_DEF  = 32;
    localparam int STEPS_WIDTH_DEF = 16;
    localparam int DWELL_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dds_sweep_timer.sv
// Dwell down-counter: load captures the reload value, reload restores it, dec counts down.
// Latency: zero_o reflects the registered count; no backpressure.
module dds_sweep_timer #(
    parameter int WIDTH = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             reload_i,
    input  logic             dec_i,
    output logic             zero_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;

    always_comb begin
        cnt_d = cnt_q;
        rld_d = rld_q;
        if (load_i) begin
            cnt_d = load_val_i;
            rld_d = load_val_i;
        end else if (reload_i) begin
            cnt_d = rld_q;
        end else if (dec_i) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
            rld_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rld_q <= rld_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear phase-increment sweep controller for a DDS; optional phase reset via DDS_SWEEP_PHASE_RESET_EN.
// Latency: pinc/step_strobe update one cycle after trigger acceptance; abort returns to IDLE next cycle.
module dds_sweep_ctrl
    import dds_sweep_pkg::*;
#(
    parameter int PINC_WIDTH  = PINC_WIDTH_DEF,
    parameter int STEPS_WIDTH = STEPS_WIDTH_DEF,
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [PINC_WIDTH-1:0]  cfg_start,
    input  logic [PINC_WIDTH-1:0]  cfg_step,
    input  logic [STEPS_WIDTH-1:0] cfg_steps,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   trigger,
    input  logic                   abort,
    output logic [PINC_WIDTH-1:0]  pinc,
    output logic                   dds_aresetn,
    output logic                   busy,
    output logic                   step_strobe,
    output logic                   done
);

    localparam logic [STEPS_WIDTH-1:0] STEPS_ONE = {{(STEPS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [PINC_WIDTH-1:0]  pinc_q, pinc_d;
    logic [PINC_WIDTH-1:0]  step_q, step_d;
    logic [STEPS_WIDTH-1:0] steps_q, steps_d;
    logic                   strobe_q, strobe_d;
    logic                   rstn_q, rstn_d;

    logic                   accept;
    logic                   tmr_load, tmr_reload, tmr_dec, tmr_zero;
    logic [DWELL_WIDTH-1:0] dwell_load;

    // A dwell of zero behaves like one: the count holds max(dwell,1)-1.
    assign dwell_load = (cfg_dwell == '0) ? '0 : (cfg_dwell - DWELL_ONE);

    dds_sweep_timer #(
        .WIDTH (DWELL_WIDTH)
    ) u_timer (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .load_i     (tmr_load),
        .load_val_i (dwell_load),
        .reload_i   (tmr_reload),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        pinc_d     = pinc_q;
        step_d     = step_q;
        steps_d    = steps_q;
        strobe_d   = 1'b0;
        accept     = 1'b0;
        tmr_load   = 1'b0;
        tmr_reload = 1'b0;
        tmr_dec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger && !abort) begin
                    accept   = 1'b1;
                    tmr_load = 1'b1;
                    pinc_d   = cfg_start;
                    step_d   = cfg_step;
                    steps_d  = cfg_steps;
                    strobe_d = 1'b1;
                    state_d  = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (steps_q != '0) begin
                    pinc_d     = pinc_q + step_q;
                    steps_d    = steps_q - STEPS_ONE;
                    tmr_reload = 1'b1;
                    strobe_d   = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef DDS_SWEEP_PHASE_RESET_EN
    // Phase reset lines up with the first cycle pinc shows cfg_start.
    assign rstn_d = ~accept;
`else
    assign rstn_d = 1'b1;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            pinc_q   <= '0;
            step_q   <= '0;
            steps_q  <= '0;
            strobe_q <= 1'b0;
            rstn_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pinc_q   <= pinc_d;
            step_q   <= step_d;
            steps_q  <= steps_d;
            strobe_q <= strobe_d;
            rstn_q   <= rstn_d;
        end
    end

    assign pinc        = pinc_q;
    assign dds_aresetn = rstn_q;
    assign busy        = (state_q == ST_DWELL);
    assign step_strobe = strobe_q;
    // An abort landing on the DONE cycle cancels the completion pulse.
    assign done        = (state_q == ST_DONE) && !abort;

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter PINC_WIDTH, default 32, DDS phase-increment width.
REQ-002 SHALL have parameter STEPS_WIDTH, default 16, step-count width.
REQ-003 SHALL have parameter DWELL_WIDTH, default 32, dwell-counter width.
REQ-004 aclk  input  1  sole clock; all logic on rising edge.
REQ-005 aresetn  input  1  asynchronous, active-low reset.
REQ-006 cfg_start  input  PINC_WIDTH  first phase increment of the sweep.
REQ-007 cfg_step  input  PINC_WIDTH  signed two's-complement increment added per step.
REQ-008 cfg_steps  input  STEPS_WIDTH  number of increments after the first value.
REQ-009 cfg_dwell  input  DWELL_WIDTH  cycles spent on each value; 0 treated as 1.
REQ-010 trigger  input  1  level-sampled sweep start request.
REQ-011 abort  input  1  level-sampled sweep cancel.
REQ-012 pinc  output  PINC_WIDTH  phase increment to DDS, registered.
REQ-013 dds_aresetn  output  1  phase-reset to DDS, active-low, registered.
REQ-014 busy  output  1  high while sweeping.
REQ-015 step_strobe  output  1  one-cycle pulse on every pinc update during a sweep.
REQ-016 done  output  1  one-cycle pulse on normal sweep completion.

Function
REQ-017 SHALL implement states IDLE, DWELL, DONE.
REQ-018 IDLE with trigger=1 and abort=0 SHALL capture all cfg_* inputs, load pinc=cfg_start, steps_left=cfg_steps, dwell_left=max(cfg_dwell,1)-1, enter DWELL next cycle, pulse step_strobe.
REQ-019 cfg_* SHALL be sampled only at trigger acceptance; later changes SHALL not affect the running sweep.
REQ-020 DWELL with dwell_left>0 SHALL decrement dwell_left.
REQ-021 DWELL with dwell_left=0 and steps_left>0 SHALL set pinc=pinc+cfg_step modulo 2^PINC_WIDTH, decrement steps_left, reload dwell_left, pulse step_strobe.
REQ-022 DWELL with dwell_left=0 and steps_left=0 SHALL enter DONE; DONE SHALL assert done for one cycle and return to IDLE.
REQ-023 Each pinc value SHALL be held exactly max(cfg_dwell,1) cycles; sweep occupies (cfg_steps+1)*max(cfg_dwell,1) DWELL cycles.
REQ-024 busy SHALL equal 1 exactly when state is DWELL.
REQ-025 trigger in DWELL or DONE SHALL be ignored.
REQ-026 abort in DWELL or DONE SHALL go to IDLE next cycle, hold pinc, suppress done and step_strobe.
REQ-027 abort and trigger both high in IDLE SHALL keep IDLE; abort wins.
REQ-028 pinc SHALL hold its last value in IDLE.

Reset
REQ-029 aresetn low SHALL asynchronously force state=IDLE, pinc=0, counters=0, busy=0, done=0, step_strobe=0, dds_aresetn=0.
REQ-030 dds_aresetn SHALL return to 1 on the first rising aclk after aresetn deasserts.
REQ-031 Reset mid-sweep SHALL discard the sweep; no done pulse.

Configuration
REQ-032 With DDS_SWEEP_PHASE_RESET_EN defined, dds_aresetn SHALL be 0 for exactly the one cycle following trigger acceptance (first cycle pinc=cfg_start), else 1.
REQ-033 Without DDS_SWEEP_PHASE_RESET_EN, dds_aresetn SHALL be 1 outside reset; port retained.

Structure
REQ-034 Package dds_sweep_pkg SHALL hold the state enum and default width constants.
REQ-035 Dwell down-counter with reload and zero flag SHALL be sub-module dds_sweep_timer.

Verification
REQ-036 start=1000, step=100, steps=3, dwell=4, trigger 1 cycle -> pinc 1000,1100,1200,1300 each 4 cycles, 4 step_strobes, done 16 cycles after first DWELL cycle.
REQ-037 dwell=0, steps=2, start=5, step=-1 -> pinc 5,4,3 each 1 cycle, done pulse, busy 3 cycles.
REQ-038 start=32'hFFFFFFF0, step=32, steps=1, dwell=2 -> second pinc=32'h00000010 (wrap).
REQ-039 abort in 2nd DWELL cycle, then trigger and abort together -> IDLE, pinc held, no done, sweep not started.
REQ-040 aresetn pulsed low mid-sweep -> pinc=0, busy=0, dds_aresetn=0 immediately; no done.
REQ-041 With DDS_SWEEP_PHASE_RESET_EN, trigger -> dds_aresetn low exactly one cycle aligned with pinc=cfg_start; without macro, stays 1.
